// File: rtl/cve2_pkg.sv
// Shared types for the MAC responder slice.
// ALU operator encoding, responder states, counter sizing.
package cve2_pkg;

  typedef enum logic [6:0] {
    ALU_ADD   = 7'd0,
    ALU_SUB   = 7'd1,
    ALU_XOR   = 7'd2,
    ALU_OR    = 7'd3,
    ALU_AND   = 7'd4,
    ALU_SLL   = 7'd5,
    ALU_SRL   = 7'd6,
    ALU_SRA   = 7'd7,
    ALU_CLMUL = 7'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    RESP = 2'd3
  } mac_rsp_state_e;

  // Width of a counter reaching t; a disabled timeout still needs 1 bit.
  function automatic int mac_timeout_w(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

  localparam int unsigned MAC_TIMEOUT_DEFAULT = 16;
  localparam int MAC_TIMEOUT_W = mac_timeout_w(MAC_TIMEOUT_DEFAULT);

endpackage

// File: rtl/cve2_mac_timeout_cnt.sv
// Saturating wait counter for one ALU step.
// expired_o flags the last allowed cycle while enabled.
module cve2_mac_timeout_cnt
  import cve2_pkg::*;
#(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = mac_timeout_w(Limit);
  localparam logic [W-1:0] Last =
    (Limit == 0) ? '0 : W'(Limit - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (Limit != 0) && en_i &&
                     (cnt_q == Last);

endmodule

// File: rtl/cve2_mac_responder.sv
// MAC responder: sequences multiply then add on the shared ALU,
// returning the sum to writeback; passes ALU traffic when idle.
module cve2_mac_responder
  import cve2_pkg::*;
#(
  parameter alu_op_e     MulOp      = ALU_CLMUL,
  parameter int unsigned MulTimeout = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [31:0] req_acc_i,
  input  logic [4:0]  req_rd_i,
  input  alu_op_e     alu_operator_i,
  input  logic [31:0] alu_operand_a_i,
  input  logic [31:0] alu_operand_b_i,
  output alu_op_e     alu_operator_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_valid_i,
  output logic        busy_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_err_o,
  input  logic        flush_i
);

  mac_rsp_state_e state_q;
  logic [31:0] a_q, b_q, acc_q;
  logic [31:0] prod_q, sum_q;
  logic [4:0]  rd_q;
  logic        err_q;

  logic cnt_en, cnt_clr, expired;

  assign cnt_en  = (state_q == MUL) ||
                   (state_q == ADD);
  assign cnt_clr = flush_i | ~cnt_en | alu_valid_i;

  cve2_mac_timeout_cnt #(
    .Limit (MulTimeout)
  ) u_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            a_q     <= req_a_i;
            b_q     <= req_b_i;
            acc_q   <= req_acc_i;
            rd_q    <= req_rd_i;
            state_q <= MUL;
          end
        end
        MUL: begin
          if (alu_valid_i) begin
            prod_q  <= alu_result_i;
            state_q <= ADD;
          end else if (expired) begin
            sum_q   <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        ADD: begin
          if (alu_valid_i) begin
            sum_q   <= alu_result_i;
            state_q <= RESP;
          end else if (expired) begin
            sum_q   <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = ~rst_i & ~flush_i &
                       (state_q == IDLE);
  assign busy_o      = ~rst_i & (state_q != IDLE);
  assign rsp_valid_o = ~rst_i & (state_q == RESP);
  assign rsp_data_o  = sum_q;
  assign rsp_rd_o    = rd_q;
  assign rsp_err_o   = err_q;

  // RESP keeps the add-step operands so the ALU inputs stay quiet.
  always_comb begin
    alu_operator_o  = alu_operator_i;
    alu_operand_a_o = alu_operand_a_i;
    alu_operand_b_o = alu_operand_b_i;
    unique case (state_q)
      IDLE: ;
      MUL: begin
        alu_operator_o  = MulOp;
        alu_operand_a_o = a_q;
        alu_operand_b_o = b_q;
      end
      ADD, RESP: begin
        alu_operator_o  = ALU_ADD;
        alu_operand_a_o = prod_q;
        alu_operand_b_o = acc_q;
      end
      default: ;
    endcase
  end

endmodule
